// File: rtl/gray_conv_pkg.sv
// +--------------------------------------------------------------------------+
// | gray_conv_pkg : mode encodings, stats width and stage-split helper        |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package gray_conv_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;
  localparam int   STATS_W  = 16;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_conv_stage.sv
// +--------------------------------------------------------------------------+
// | gray_conv_stage : one pipeline slot resolving an MSB-first Gray slice     |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module gray_conv_stage
  import gray_conv_pkg::*;
#(
  parameter int size   = 10,
  parameter int stages = 2,
  parameter int idx    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_mode,
  input  logic [size-1:0] in_data,
  input  logic            load,
  output logic            out_valid,
  output logic            out_mode,
  output logic [size-1:0] out_data
);

  localparam int c_chunk = ceil_div(size, stages);
  localparam int c_hi    = size - 1 - idx * c_chunk;
  localparam int c_lo    = (size - (idx + 1) * c_chunk > 0) ? size - (idx + 1) * c_chunk : 0;

  logic            valid_q, valid_d;
  logic            mode_q, mode_d;
  logic [size-1:0] data_q, data_d;
  logic [size-1:0] w_conv;
  logic            w_run;

  // Bits above c_hi already hold results; bit c_hi+1 seeds the running XOR.
  always_comb begin
    w_conv = in_data;
    w_run  = 1'b0;
    if (in_mode == MODE_G2B) begin
      for (int i = size - 1; i >= 0; i--) begin
        if (i == c_hi + 1) begin
          w_run = in_data[i];
        end else if (i <= c_hi && i >= c_lo) begin
          w_run     = w_run ^ in_data[i];
          w_conv[i] = w_run;
        end
      end
    end else if (idx == 0) begin
      w_conv = in_data ^ (in_data >> 1);
    end
  end

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        mode_d = in_mode;
        data_d = w_conv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_mode  = mode_q;
  assign out_data  = data_q;

endmodule

`default_nettype wire

// File: rtl/gray_conv_pipe.sv
// +--------------------------------------------------------------------------+
// | gray_conv_pipe : valid/ready pipelined binary<->Gray converter            |
// | Optional stats counters enabled by GRAY_CONV_PIPE_STATS_EN. Revision 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module gray_conv_pipe
  import gray_conv_pkg::*;
#(
  parameter int size   = 10,
  parameter int stages = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [size-1:0]    data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [size-1:0]    data_out,
  output logic               mode_out
`ifdef GRAY_CONV_PIPE_STATS_EN
  ,
  output logic [STATS_W-1:0] beat_cnt,
  output logic [STATS_W-1:0] stall_cnt
`endif
);

  logic [stages:0] w_valid;
  logic [stages:0] w_mode;
  logic [stages:0] w_ready;
  logic [size-1:0] w_data [stages+1];

  assign w_valid[0] = in_valid;
  assign w_mode[0]  = mode;
  assign w_data[0]  = data_in;

  // A slot may load when it is empty or everything downstream of it can shift.
  always_comb begin
    w_ready[stages] = out_ready;
    for (int k = stages - 1; k >= 0; k--) begin
      w_ready[k] = !w_valid[k+1] || w_ready[k+1];
    end
  end

  for (genvar k = 0; k < stages; k++) begin : g_stage
    gray_conv_stage #(
      .size   (size),
      .stages (stages),
      .idx    (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (w_valid[k]),
      .in_mode   (w_mode[k]),
      .in_data   (w_data[k]),
      .load      (w_ready[k]),
      .out_valid (w_valid[k+1]),
      .out_mode  (w_mode[k+1]),
      .out_data  (w_data[k+1])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[stages];
  assign mode_out  = w_mode[stages];
  assign data_out  = w_data[stages];

`ifdef GRAY_CONV_PIPE_STATS_EN
  localparam logic [STATS_W-1:0] c_one = {{(STATS_W-1){1'b0}}, 1'b1};

  logic [STATS_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [STATS_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_valid && out_ready && beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + c_one;
    if (out_valid && !out_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + c_one;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/gray_conv_pipe.md
GRAY_CONV_PIPE -- requirements
Module: gray_conv_pipe

Interface
REQ-001 Parameter size, default 10: data width in bits, legal range 2..64.
REQ-002 Parameter stages, default 2: pipeline depth, legal range 1..4; stages greater than size is illegal.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the input beat is valid.
REQ-006 Port in_ready, output, 1 bit: the block accepts the input beat this cycle.
REQ-007 Port mode, input, 1 bit: 0 selects binary-to-Gray, 1 selects Gray-to-binary; sampled with data_in.
REQ-008 Port data_in, input, size bits: operand.
REQ-009 Port out_valid, output, 1 bit: the result beat is valid.
REQ-010 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 Port data_out, output, size bits: converted result.
REQ-012 Port mode_out, output, 1 bit: the mode that travelled with the result.

Function
REQ-013 A beat is accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-014 A beat is delivered when out_valid and out_ready are both high on a rising clk edge.
REQ-015 Binary-to-Gray: data_out equals the operand XOR (the operand shifted right by 1).
REQ-016 Gray-to-binary: data_out[i] equals the XOR of operand bits size-1 down to i (prefix XOR from MSB).
REQ-017 Gray-to-binary work is split MSB-first: each stage resolves ceil(size/stages) result bits and carries the remaining operand bits forward.
REQ-018 Binary-to-Gray results are computed in stage 1 and carried unchanged through the later stages.
REQ-019 Each stage holds a valid bit, the partial data and the mode.
REQ-020 A stage loads when it is empty or when its content moves on in the same cycle.
REQ-021 Latency is exactly stages cycles from acceptance to out_valid when there is no backpressure.
REQ-022 Throughput is 1 beat per cycle.
REQ-023 Modes may be mixed back-to-back with no bubble.
REQ-024 in_ready is 0 only when every stage is full and out_ready is 0; in_ready may depend combinationally on out_ready.
REQ-025 Once out_valid is high, data_out and mode_out stay stable until the beat is delivered.
REQ-026 Beats are never dropped, duplicated or reordered.
REQ-027 Simultaneous accept and deliver while full keeps the occupancy unchanged.
REQ-028 in_valid with data_in all-zero or all-one is legal in both modes and needs no special case.

Reset
REQ-029 While rst_n is 0 at a clk edge, all stage valid bits clear, out_valid is 0, and data_out and mode_out are 0.
REQ-030 Reset applied mid-operation discards every in-flight beat.
REQ-031 in_ready is 1 in the first cycle after reset release.
REQ-032 No beat is accepted on a clk edge where rst_n is 0.

Configuration
REQ-033 When the macro GRAY_CONV_PIPE_STATS_EN is defined, the block adds output beat_cnt, 16 bits: deliveries, saturating at 16'hFFFF.
REQ-034 When GRAY_CONV_PIPE_STATS_EN is defined, the block also adds output stall_cnt, 16 bits: cycles with out_valid=1 and out_ready=0, saturating at 16'hFFFF.
REQ-035 beat_cnt and stall_cnt reset to 0.
REQ-036 When GRAY_CONV_PIPE_STATS_EN is not defined, beat_cnt and stall_cnt are absent, and the ports and logic are otherwise identical.

Structure
REQ-037 A shared package gray_conv_pkg holds the mode encoding constants (MODE_B2G=0, MODE_G2B=1) and the stats counter width constant (16).
REQ-038 One sub-module, gray_conv_stage, implements a single pipeline stage (valid/data/mode register plus partial prefix-XOR slice) and is instantiated stages times.

Verification
REQ-039 With size=10 and stages=2: mode 0, data_in 10'h005 -> data_out 10'h007 and mode_out 0, two cycles after acceptance.
REQ-040 With size=10 and stages=2: mode 1, data_in 10'h200 -> data_out 10'h3FF; mode 0, data_in 10'h3FF -> data_out 10'h200.
REQ-041 Hold out_ready=0 for 6 cycles while sending 10'h001, 10'h002, 10'h003 and 10'h004 with in_valid held -> in_ready drops after 2 beats are held, then all 4 beats arrive in order once out_ready=1, with no loss.
REQ-042 Send an alternating-mode stream of 1024 values (0..1023) in each mode with out_ready=1 -> the round trip through bin->gray->bin matches every value, and one result is delivered per cycle.
REQ-043 Assert rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, no stale beat is ever delivered, and in_ready=1.
REQ-044 With GRAY_CONV_PIPE_STATS_EN defined, deliver 5 beats including 3 stall cycles -> beat_cnt=5 and stall_cnt=3; force 70000 deliveries -> beat_cnt holds at 16'hFFFF.
